// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, signed or unsigned per request.
// Valid/ready request and response channels; one division in flight.
module iter_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic          dbz_q, dbz_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          sa_in, sb_in;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    r_shift, diff;

  // Next-state and datapath for the IDLE/CALC/DONE sequence
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;

    sa_in   = is_signed & dividend[W-1];
    sb_in   = is_signed & divisor[W-1];
    a_mag   = sa_in ? -dividend : dividend;
    b_mag   = sb_in ? -divisor : divisor;
    // MIN negates to itself, which is exactly its unsigned magnitude
    r_shift = {r_q, q_q[W-1]};
    diff    = r_shift - {1'b0, b_q};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sa_d = sa_in;
          sb_d = sb_in;
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = a_mag;
            r_d     = '0;
            b_d     = b_mag;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (!diff[W]) begin
          r_d = diff[W-1:0];
          q_d = {q_q[W-2:0], 1'b1};
        end else begin
          r_d = r_shift[W-1:0];
          q_d = {q_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          quot_d  = (sa_q ^ sb_q) ? -q_d : q_d;
          rem_d   = sa_q ? -r_d : r_d;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
